// File: rtl/neopixel_pkg.sv
// Shared definitions for the NeoPixel driver and the pattern controllers that feed it.
package neopixel_pkg;

    // Transmitter states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        LATCH = 2'd2
    } state_t;

    // Colour indices as seen on the write port
    localparam logic [1:0] RED   = 2'd0;
    localparam logic [1:0] GREEN = 2'd1;
    localparam logic [1:0] BLUE  = 2'd2;

    // Default strip size and WS2812 timing at 50 MHz
    localparam int DEF_NUM_PIXELS = 5;
    localparam int DEF_T0H        = 18;
    localparam int DEF_T1H        = 35;
    localparam int DEF_T_BIT      = 63;
    localparam int DEF_T_RESET    = 2600;

    localparam int BITS_PER_PIXEL = 24;

    // The strip expects G, R, B on the wire; map a byte slot (0..2) to a colour index
    function automatic logic [1:0] wire_order_color(input logic [1:0] byte_slot);
        logic [1:0] color;
        case (byte_slot)
            2'd0:    color = GREEN;
            2'd1:    color = RED;
            default: color = BLUE;
        endcase
        return color;
    endfunction

endpackage

// File: rtl/counter.sv
// Generic up-counter with synchronous clear (priority) and count enable.
module counter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    // Clear wins over enable; the owner clears before the counter can overflow
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/neopixel_frame_buf.sv
// Frame buffer: NUM_PIXELS x 3 colour bytes, range-checked write port and a
// combinational read port addressed by frame bit number (wire order G,R,B, MSB first).
module neopixel_frame_buf
    import neopixel_pkg::*;
#(
    parameter int NUM_PIXELS = DEF_NUM_PIXELS,
    parameter int BIT_W      = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [2:0]       wr_pixel,
    input  logic [1:0]       wr_color,
    input  logic [7:0]       wr_level,
    input  logic [BIT_W-1:0] rd_bit,
    output logic             rd_data
);

    logic [7:0]            level_reg [NUM_PIXELS][3];
    logic                  wr_ok;
    logic [BIT_W-1:0]      rd_pixel;
    logic [BIT_W-1:0]      rd_pos;
    logic [1:0]            rd_color;
    logic [2:0]            rd_bit_sel;
    logic [NUM_PIXELS-1:0] pix_bit;

    // Out-of-range pixels and colour index 3 are silently dropped
    assign wr_ok = wr_en && ({1'b0, wr_pixel} < 4'(NUM_PIXELS)) && (wr_color != 2'd3);

    // Storage: cleared by reset, one byte updated per accepted write
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < NUM_PIXELS; p++) begin
                for (int c = 0; c < 3; c++) begin
                    level_reg[p][c] <= '0;
                end
            end
        end else if (wr_ok) begin
            for (int p = 0; p < NUM_PIXELS; p++) begin
                for (int c = 0; c < 3; c++) begin
                    if (wr_pixel == 3'(p) && wr_color == 2'(c)) begin
                        level_reg[p][c] <= wr_level;
                    end
                end
            end
        end
    end

    // Split the frame bit number into pixel, byte slot and bit-within-byte
    assign rd_pixel   = rd_bit / BIT_W'(BITS_PER_PIXEL);
    assign rd_pos     = rd_bit % BIT_W'(BITS_PER_PIXEL);
    assign rd_color   = wire_order_color(rd_pos[4:3]);
    assign rd_bit_sel = ~rd_pos[2:0];

    // Per-pixel candidate bit for the current colour and bit position
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PIXELS; gi++) begin : g_pix
            assign pix_bit[gi] = level_reg[gi][rd_color][rd_bit_sel];
        end
    endgenerate

    // Pick the addressed pixel; bit numbers past the frame read as 0
    always_comb begin
        rd_data = 1'b0;
        for (int p = 0; p < NUM_PIXELS; p++) begin
            if (rd_pixel == BIT_W'(p)) begin
                rd_data = pix_bit[p];
            end
        end
    end

endmodule

// File: rtl/neopixel_tx.sv
// WS2812 transmitter: buffers per-colour writes, serialises the whole frame on
// send_it with WS2812 bit timing, then holds the line low for the latch gap.
module neopixel_tx
    import neopixel_pkg::*;
#(
    parameter int NUM_PIXELS = DEF_NUM_PIXELS,
    parameter int T0H        = DEF_T0H,
    parameter int T1H        = DEF_T1H,
    parameter int T_BIT      = DEF_T_BIT,
    parameter int T_RESET    = DEF_T_RESET
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] pixel_index,
    input  logic [1:0] color_index,
    input  logic [7:0] color_level,
    input  logic       load_color,
    input  logic       send_it,
    output logic       neo_data,
    output logic       ready_to_load,
    output logic       ready_to_send
);

    localparam int FRAME_BITS = BITS_PER_PIXEL * NUM_PIXELS;
    localparam int TICK_W     = $clog2(T_BIT);
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam int LATCH_W    = $clog2(T_RESET + 1);

    state_t               state_reg, state_next;
    logic                 neo_reg, neo_next;
    logic [TICK_W-1:0]    tick_count;
    logic [BIT_W-1:0]     bit_count;
    logic [LATCH_W-1:0]   latch_count;
    logic                 tick_last, bit_last, latch_last;
    logic                 in_idle, in_send, in_latch;
    logic                 cur_bit;
    logic [TICK_W:0]      high_width;
    logic [TICK_W:0]      tick_plus;

    assign in_idle  = (state_reg == IDLE);
    assign in_send  = (state_reg == SEND);
    assign in_latch = (state_reg == LATCH);

    assign tick_last  = (tick_count == TICK_W'(T_BIT - 1));
    assign bit_last   = (bit_count == BIT_W'(FRAME_BITS - 1));
    assign latch_last = (latch_count == LATCH_W'(T_RESET - 1));

    // tick_count is the position within the bit currently on the wire
    counter #(.WIDTH(TICK_W)) u_tick_cnt (
        .clock  (clock),
        .reset  (reset),
        .clear  (!in_send || tick_last),
        .enable (in_send),
        .count  (tick_count)
    );

    // bit_count is the frame bit currently on the wire
    counter #(.WIDTH(BIT_W)) u_bit_cnt (
        .clock  (clock),
        .reset  (reset),
        .clear  (!in_send),
        .enable (in_send && tick_last),
        .count  (bit_count)
    );

    // latch_count is the number of latch cycles already spent
    counter #(.WIDTH(LATCH_W)) u_latch_cnt (
        .clock  (clock),
        .reset  (reset),
        .clear  (!in_latch),
        .enable (in_latch),
        .count  (latch_count)
    );

    // Writes only land while idle, so the frame cannot change mid-transmission
    neopixel_frame_buf #(
        .NUM_PIXELS (NUM_PIXELS),
        .BIT_W      (BIT_W)
    ) u_frame_buf (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (load_color && in_idle),
        .wr_pixel (pixel_index),
        .wr_color (color_index),
        .wr_level (color_level),
        .rd_bit   (bit_count),
        .rd_data  (cur_bit)
    );

    assign high_width = cur_bit ? (TICK_W + 1)'(T1H) : (TICK_W + 1)'(T0H);
    assign tick_plus  = {1'b0, tick_count} + (TICK_W + 1)'(1);

    // State and serial line registers; neo_data comes straight from a flop
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            neo_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            neo_reg   <= neo_next;
        end
    end

    // Next state and next line level; every bit starts high, so a new bit always sets neo_next
    always_comb begin
        state_next = state_reg;
        neo_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (send_it) begin
                    state_next = SEND;
                    neo_next   = 1'b1;
                end
            end
            SEND: begin
                if (tick_last) begin
                    if (bit_last) begin
                        state_next = LATCH;
                    end else begin
                        neo_next = 1'b1;
                    end
                end else begin
                    neo_next = (tick_plus < high_width);
                end
            end
            LATCH: begin
                if (latch_last) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign neo_data      = neo_reg;
    assign ready_to_load = in_idle;
    assign ready_to_send = in_idle;

endmodule

// File: tb/tb_neopixel_tx.sv
// Directed bench for neopixel_tx: table of write/frame vectors plus hand-written
// sequences for same-edge load/send and reset in the middle of a frame.
module tb_neopixel_tx;
    import neopixel_pkg::*;

    localparam int NP = 5;
    localparam int T0 = 18;
    localparam int T1 = 35;
    localparam int TB = 63;
    localparam int TR = 2600;
    localparam int FB = 24 * NP;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] pixel_index;
    logic [1:0] color_index;
    logic [7:0] color_level;
    logic       load_color;
    logic       send_it;
    logic       neo_data;
    logic       ready_to_load;
    logic       ready_to_send;

    int checks = 0;
    int passes = 0;

    always #10 clock = ~clock;

    neopixel_tx #(
        .NUM_PIXELS (NP),
        .T0H        (T0),
        .T1H        (T1),
        .T_BIT      (TB),
        .T_RESET    (TR)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .pixel_index   (pixel_index),
        .color_index   (color_index),
        .color_level   (color_level),
        .load_color    (load_color),
        .send_it       (send_it),
        .neo_data      (neo_data),
        .ready_to_load (ready_to_load),
        .ready_to_send (ready_to_send)
    );

    typedef struct packed {
        logic [2:0]      wen;
        logic [2:0][2:0] pix;
        logic [2:0][1:0] col;
        logic [2:0][7:0] lvl;
        logic            inject;
        logic [FB-1:0]   exp_bits;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input int act, input int exp_val);
        checks++;
        if (act == exp_val) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp_val);
    endtask

    task automatic do_write(input logic [2:0] pix, input logic [1:0] col, input logic [7:0] lvl);
        @(negedge clock);
        check("ready_to_load before write", int'(ready_to_load), 1);
        pixel_index = pix;
        color_index = col;
        color_level = lvl;
        load_color  = 1'b1;
        @(negedge clock);
        load_color  = 1'b0;
        $display("write pixel %0d colour %0d level %02h", pix, col, lvl);
    endtask

    // Send one frame and measure every bit period, the latch gap and ready timing
    task automatic run_frame(input string tag, input logic [FB-1:0] exp_bits, input logic inject,
                             input logic co_load, input logic [2:0] co_pix,
                             input logic [1:0] co_col, input logic [7:0] co_lvl);
        int width [FB];
        bit seen_low [FB];
        int shape_bad = 0;
        int send_ready = 0;
        int latch_high = 0;
        int latch_ready = 0;
        int bad_bits = 0;
        @(negedge clock);
        check({tag, " ready_to_send before send"}, int'(ready_to_send), 1);
        send_it = 1'b1;
        if (co_load) begin
            pixel_index = co_pix;
            color_index = co_col;
            color_level = co_lvl;
            load_color  = 1'b1;
        end
        for (int b = 0; b < FB; b++) begin
            width[b] = 0;
            seen_low[b] = 1'b0;
        end
        for (int c = 0; c < FB * TB; c++) begin
            @(negedge clock);
            if (c == 0) begin
                send_it    = 1'b0;
                load_color = 1'b0;
            end
            if (neo_data) begin
                width[c / TB]++;
                if (seen_low[c / TB]) shape_bad++;
            end else begin
                seen_low[c / TB] = 1'b1;
            end
            if (ready_to_load || ready_to_send) send_ready++;
            if (inject && c == 700) begin
                pixel_index = 3'd0;
                color_index = GREEN;
                color_level = 8'hFF;
                load_color  = 1'b1;
                send_it     = 1'b1;
            end else if (inject && c == 701) begin
                load_color  = 1'b0;
                send_it     = 1'b0;
            end
        end
        for (int c = 0; c < TR; c++) begin
            @(negedge clock);
            if (neo_data) latch_high++;
            if (ready_to_load || ready_to_send) latch_ready++;
        end
        @(negedge clock);
        for (int b = 0; b < FB; b++) begin
            check($sformatf("%s bit%0d high width", tag, b), width[b], exp_bits[b] ? T1 : T0);
            if (width[b] != (exp_bits[b] ? T1 : T0)) bad_bits++;
        end
        check({tag, " pulse shape"}, shape_bad, 0);
        check({tag, " ready during SEND"}, send_ready, 0);
        check({tag, " neo_data high during LATCH"}, latch_high, 0);
        check({tag, " ready during LATCH"}, latch_ready, 0);
        check({tag, " ready_to_load at k+10161"}, int'(ready_to_load), 1);
        check({tag, " ready_to_send at k+10161"}, int'(ready_to_send), 1);
        $display("frame %s: %0d bits with wrong width", tag, bad_bits);
    endtask

    initial begin
        logic [FB-1:0] exp_bits;
        int idle_bad;

        reset = 1'b1;
        pixel_index = '0;
        color_index = '0;
        color_level = '0;
        load_color  = 1'b0;
        send_it     = 1'b0;

        for (int i = 0; i < 4; i++) vecs[i] = '0;
        // Untouched buffer: all zero bits
        // Pixel 0 green = A5
        vecs[1].wen = 3'b001;
        vecs[1].pix[0] = 3'd0; vecs[1].col[0] = GREEN; vecs[1].lvl[0] = 8'hA5;
        vecs[1].exp_bits[0] = 1'b1; vecs[1].exp_bits[2] = 1'b1;
        vecs[1].exp_bits[5] = 1'b1; vecs[1].exp_bits[7] = 1'b1;
        // Clear pixel 0 green, pixel 4 blue = 01, colour-3 write ignored; mid-frame pulses
        vecs[2].wen = 3'b111;
        vecs[2].pix[0] = 3'd0; vecs[2].col[0] = GREEN;  vecs[2].lvl[0] = 8'h00;
        vecs[2].pix[1] = 3'd4; vecs[2].col[1] = BLUE;   vecs[2].lvl[1] = 8'h01;
        vecs[2].pix[2] = 3'd2; vecs[2].col[2] = 2'd3;   vecs[2].lvl[2] = 8'hFF;
        vecs[2].inject = 1'b1;
        vecs[2].exp_bits[119] = 1'b1;
        // Clear pixel 4 blue, pixel 3 red = 3C, pixel 5 out of range ignored
        vecs[3].wen = 3'b111;
        vecs[3].pix[0] = 3'd4; vecs[3].col[0] = BLUE;  vecs[3].lvl[0] = 8'h00;
        vecs[3].pix[1] = 3'd3; vecs[3].col[1] = RED;   vecs[3].lvl[1] = 8'h3C;
        vecs[3].pix[2] = 3'd5; vecs[3].col[2] = GREEN; vecs[3].lvl[2] = 8'hFF;
        vecs[3].exp_bits[82] = 1'b1; vecs[3].exp_bits[83] = 1'b1;
        vecs[3].exp_bits[84] = 1'b1; vecs[3].exp_bits[85] = 1'b1;

        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("reset neo_data", int'(neo_data), 0);
        check("reset ready_to_load", int'(ready_to_load), 1);
        check("reset ready_to_send", int'(ready_to_send), 1);

        idle_bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clock);
            if (neo_data || !ready_to_load || !ready_to_send) idle_bad++;
        end
        check("idle 100 cycles", idle_bad, 0);

        for (int i = 0; i < 4; i++) begin
            for (int w = 0; w < 3; w++) begin
                if (vecs[i].wen[w]) do_write(vecs[i].pix[w], vecs[i].col[w], vecs[i].lvl[w]);
            end
            run_frame($sformatf("vec%0d", i), vecs[i].exp_bits, vecs[i].inject, 1'b0, 3'd0, 2'd0, 8'd0);
        end

        // Same-edge write and send: pixel 1 red MSB is frame bit 32
        exp_bits = vecs[3].exp_bits;
        exp_bits[32] = 1'b1;
        run_frame("same_edge", exp_bits, 1'b0, 1'b1, 3'd1, RED, 8'h80);

        // Reset in the middle of a frame while the line is high (bit 47, tick 8)
        @(negedge clock);
        send_it = 1'b1;
        @(negedge clock);
        send_it = 1'b0;
        repeat (2969) @(negedge clock);
        check("mid-frame neo_data high before reset", int'(neo_data), 1);
        #2 reset = 1'b1;
        #1;
        check("neo_data drops on async reset", int'(neo_data), 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("ready_to_load after reset release", int'(ready_to_load), 1);
        check("ready_to_send after reset release", int'(ready_to_send), 1);
        check("neo_data after reset release", int'(neo_data), 0);
        $display("reset applied mid-frame");

        exp_bits = '0;
        run_frame("after_reset", exp_bits, 1'b0, 1'b0, 3'd0, 2'd0, 8'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
